fir_sequencer: RTL

//  Parametrised N-tap successor to the 4-tap FIR controller. Sequences a register-file + ALU datapath:

---
 rtl/fir_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fir_sequencer.sv
// N-tap FIR controller driving a register-file + ALU datapath: sample/coefficient loads, delay-line shift, MAC loop.
// Optional macro FIR_ALT_SIGN_EN: alternate ADD/SUB per tap in the accumulate step.
module fir_sequencer #(
  parameter int NUM_TAPS   = 4,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  dr,
  input  logic                  lc,
  input  logic                  overflow,
  output logic                  cnt_up,
  output logic                  clear,
  output logic                  modwait,
  output logic                  err,
  output logic [2:0]            op,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic [REG_ADDR_W-1:0] dest
);

  typedef enum logic [3:0] {
    S_IDLE, S_EIDLE, S_LOADC, S_LOAD, S_ZERO, S_SHIFT, S_INSERT, S_MUL, S_ACC
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_COPY  = 3'd1;
  localparam logic [2:0] OP_LOAD1 = 3'd2;
  localparam logic [2:0] OP_LOAD2 = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  // Register map: R0 accumulator, R1 temp, delay line from R2, coefficients after it.
  localparam logic [REG_ADDR_W-1:0] R_ACC  = REG_ADDR_W'(0);
  localparam logic [REG_ADDR_W-1:0] R_TMP  = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] S_BASE = REG_ADDR_W'(2);
  localparam logic [REG_ADDR_W-1:0] F_BASE = REG_ADDR_W'(NUM_TAPS + 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
  logic [CNT_W-1:0] coef_idx_q, coef_idx_d;
  logic             modwait_q;

  logic [REG_ADDR_W-1:0] tap_a;
  logic [REG_ADDR_W-1:0] coef_a;
  logic [2:0]            acc_op;

  assign tap_a  = REG_ADDR_W'(tap_cnt_q);
  assign coef_a = REG_ADDR_W'(coef_idx_q);

`ifdef FIR_ALT_SIGN_EN
  assign acc_op = tap_cnt_q[0] ? OP_SUB : OP_ADD;
`else
  assign acc_op = OP_ADD;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      tap_cnt_q  <= '0;
      coef_idx_q <= '0;
      modwait_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_cnt_q  <= tap_cnt_d;
      coef_idx_q <= coef_idx_d;
      modwait_q  <= !((state_d == S_IDLE) || (state_d == S_EIDLE));
    end
  end

  assign modwait = modwait_q;

  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    coef_idx_d = coef_idx_q;
    op         = OP_NOP;
    src1       = '0;
    src2       = '0;
    dest       = '0;
    cnt_up     = 1'b0;
    clear      = 1'b0;
    err        = 1'b0;

    case (state_q)
      S_IDLE, S_EIDLE: begin
        err = (state_q == S_EIDLE);
        // A sample wins over a simultaneous coefficient load; the load is dropped.
        if (dr)      state_d = S_LOAD;
        else if (lc) state_d = S_LOADC;
      end
      S_LOADC: begin
        op         = OP_LOAD2;
        dest       = F_BASE + coef_a;
        clear      = (coef_idx_q == '0);
        coef_idx_d = (coef_idx_q == LAST_TAP) ? '0 : coef_idx_q + 1'b1;
        state_d    = S_IDLE;
      end
      S_LOAD: begin
        op      = OP_LOAD1;
        dest    = R_TMP;
        cnt_up  = 1'b1;
        state_d = dr ? S_ZERO : S_EIDLE;
      end
      S_ZERO: begin
        op        = OP_SUB;
        tap_cnt_d = LAST_TAP;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        op        = OP_COPY;
        src1      = S_BASE + tap_a - REG_ADDR_W'(1);
        dest      = S_BASE + tap_a;
        tap_cnt_d = tap_cnt_q - 1'b1;
        if (tap_cnt_q == CNT_W'(1)) state_d = S_INSERT;
      end
      S_INSERT: begin
        op        = OP_COPY;
        src1      = R_TMP;
        dest      = S_BASE;
        tap_cnt_d = '0;
        state_d   = S_MUL;
      end
      S_MUL: begin
        op      = OP_MUL;
        src1    = S_BASE + tap_a;
        src2    = F_BASE + tap_a;
        dest    = R_TMP;
        state_d = S_ACC;
      end
      S_ACC: begin
        op   = acc_op;
        src1 = R_ACC;
        src2 = R_TMP;
        dest = R_ACC;
        if (overflow) begin
          state_d = S_EIDLE;
        end else if (tap_cnt_q == LAST_TAP) begin
          state_d = S_IDLE;
        end else begin
          tap_cnt_d = tap_cnt_q + 1'b1;
          state_d   = S_MUL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
